// File: rtl/traffic_light_pkg.sv
// Shared types and constants for the traffic light sequencer: state encoding,
// register map, lamp bit positions and per-state lamp codes.
package traffic_light_pkg;

    typedef enum logic [1:0] {
        ST_STOP   = 2'd0,
        ST_RED    = 2'd1,
        ST_GREEN  = 2'd2,
        ST_YELLOW = 2'd3
    } tl_state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_GREEN  = 2'd1;
    localparam logic [1:0] ADDR_YELLOW = 2'd2;
    localparam logic [1:0] ADDR_RED    = 2'd3;

    localparam int unsigned CTRL_RUN_BIT = 0;
    localparam int unsigned CTRL_PED_BIT = 1;

    localparam int unsigned LAMP_RED_BIT    = 0;
    localparam int unsigned LAMP_YELLOW_BIT = 1;
    localparam int unsigned LAMP_GREEN_BIT  = 2;

    localparam logic [2:0] LAMP_RED    = 3'(1 << LAMP_RED_BIT);
    localparam logic [2:0] LAMP_YELLOW = 3'(1 << LAMP_YELLOW_BIT);
    localparam logic [2:0] LAMP_GREEN  = 3'(1 << LAMP_GREEN_BIT);

    // STOP shows red so the junction is safe whenever the sequencer is idle.
    function automatic logic [2:0] lamp_for(input tl_state_t s);
        case (s)
            ST_GREEN:  return LAMP_GREEN;
            ST_YELLOW: return LAMP_YELLOW;
            default:   return LAMP_RED;
        endcase
    endfunction

    // A zero duration still has to last one tick.
    function automatic logic [15:0] phase_load(input logic [15:0] dur);
        return (dur == 16'd0) ? 16'd1 : dur;
    endfunction

endpackage

// File: rtl/traffic_light_tick_gen.sv
// Timing prescaler: free-running 0..TICK_DIV-1 counter that flags a tick on
// its last count; held at zero while clear is asserted.
module traffic_light_tick_gen #(
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/traffic_light_sequencer.sv
// Avalon-MM slave that sequences red -> green -> yellow with programmable
// phase durations and a pedestrian request that shortens green.
module traffic_light_sequencer
    import traffic_light_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 50000,
    parameter logic [15:0] DEF_RED    = 16'd5000,
    parameter logic [15:0] DEF_GREEN  = 16'd4000,
    parameter logic [15:0] DEF_YELLOW = 16'd1000,
    parameter logic [15:0] PED_GREEN  = 16'd500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        ped_req,
    output logic [2:0]  out_port
);

    tl_state_t   r_state;
    logic        r_run;
    logic        r_ped_pending;
    logic [15:0] r_cnt;
    logic [15:0] r_dur_red;
    logic [15:0] r_dur_green;
    logic [15:0] r_dur_yellow;
    logic        r_ped_s1;
    logic        r_ped_s2;
    logic        r_ped_d;

    logic        w_wr;
    logic        w_wr_ctrl;
    logic        w_stop;
    logic        w_tick;
    logic        w_expire;
    logic        w_enter;
    logic        w_ped_rise;
    logic        w_ped_set;
    logic        w_ped_cap;
    logic [15:0] w_load;
    tl_state_t   w_next;
    logic        w_unused;

    assign w_unused = &{1'b0, writedata[31:16]};

    traffic_light_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clear (r_state == ST_STOP),
        .tick  (w_tick)
    );

    assign w_wr       = chipselect && !write_n;
    assign w_wr_ctrl  = w_wr && (address == ADDR_CTRL);
    // Writing run=0 stops on the very edge that samples the write, ahead of any expiry.
    assign w_stop     = !r_run || (w_wr_ctrl && !writedata[CTRL_RUN_BIT]);
    assign w_expire   = w_tick && (r_cnt == 16'd1);
    assign w_ped_rise = r_ped_s2 && !r_ped_d;
    assign w_ped_set  = w_ped_rise || (w_wr_ctrl && writedata[CTRL_PED_BIT]);
    assign w_ped_cap  = (r_state == ST_GREEN) && r_ped_pending && (r_cnt > PED_GREEN);
    assign w_enter    = (w_next != r_state);

    always_comb begin
        w_next = r_state;
        if (w_stop) begin
            w_next = ST_STOP;
        end else begin
            case (r_state)
                ST_STOP:   w_next = ST_RED;
                ST_RED:    if (w_expire) w_next = ST_GREEN;
                ST_GREEN:  if (w_expire) w_next = ST_YELLOW;
                ST_YELLOW: if (w_expire) w_next = ST_RED;
                default:   w_next = ST_STOP;
            endcase
        end
    end

    always_comb begin
        w_load = 16'd0;
        case (w_next)
            ST_RED:    w_load = phase_load(r_dur_red);
            ST_GREEN:  w_load = phase_load(r_dur_green);
            ST_YELLOW: w_load = phase_load(r_dur_yellow);
            default:   w_load = 16'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_STOP;
            out_port      <= LAMP_RED;
            r_run         <= 1'b0;
            r_ped_pending <= 1'b0;
            r_cnt         <= '0;
            r_dur_red     <= DEF_RED;
            r_dur_green   <= DEF_GREEN;
            r_dur_yellow  <= DEF_YELLOW;
            r_ped_s1      <= 1'b0;
            r_ped_s2      <= 1'b0;
            r_ped_d       <= 1'b0;
        end else begin
            r_ped_s1 <= ped_req;
            r_ped_s2 <= r_ped_s1;
            r_ped_d  <= r_ped_s2;

            r_state  <= w_next;
            out_port <= lamp_for(w_next);

            if (w_enter) begin
                r_cnt <= w_load;
            end else if (w_ped_cap) begin
                r_cnt <= PED_GREEN;
            end else if (w_tick && (r_state != ST_STOP)) begin
                r_cnt <= r_cnt - 16'd1;
            end

            if (w_ped_set) begin
                r_ped_pending <= 1'b1;
            end else if (w_enter && (w_next == ST_RED)) begin
                r_ped_pending <= 1'b0;
            end

            if (w_wr) begin
                case (address)
                    ADDR_CTRL:   r_run        <= writedata[CTRL_RUN_BIT];
                    ADDR_GREEN:  r_dur_green  <= writedata[15:0];
                    ADDR_YELLOW: r_dur_yellow <= writedata[15:0];
                    ADDR_RED:    r_dur_red    <= writedata[15:0];
                    default:     r_run        <= r_run;
                endcase
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL:   readdata = {27'd0, r_ped_pending, r_state, 1'b0, r_run};
            ADDR_GREEN:  readdata = {16'd0, r_dur_green};
            ADDR_YELLOW: readdata = {16'd0, r_dur_yellow};
            ADDR_RED:    readdata = {16'd0, r_dur_red};
            default:     readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Directed scoreboard bench for traffic_light_sequencer with a 4-cycle tick.
module tb_traffic_light_sequencer;

    localparam int unsigned TD = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        ped_req = 1'b0;
    logic [2:0]  out_port;

    traffic_light_sequencer #(
        .TICK_DIV   (TD),
        .DEF_RED    (16'd5000),
        .DEF_GREEN  (16'd4000),
        .DEF_YELLOW (16'd1000),
        .PED_GREEN  (16'd500)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .ped_req    (ped_req),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_vec = 0;
    int  n_err = 0;

    always @(negedge clk) begin
        n_vec++;
        assert ($onehot(out_port)) else begin
            n_err++;
            $error("FAIL lamp_onehot observed=%b required=one-hot", out_port);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic push(input string tag, input logic [31:0] e);
        sb_t it;
        it.tag = tag;
        it.exp = e;
        sb_q.push_back(it);
    endtask

    task automatic check(input logic [31:0] obs);
        sb_t it;
        n_vec++;
        if (sb_q.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty observed=%0d required=queued entry", obs);
        end else begin
            it = sb_q.pop_front();
            assert (obs === it.exp) else begin
                n_err++;
                $error("FAIL %s observed=%0d required=%0d", it.tag, obs, it.exp);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
        address = 2'd0;
    endtask

    // Edges from the current sample until CTRL reports state tgt.
    task automatic wait_state(input logic [1:0] tgt, input int max, output int n);
        logic [31:0] v;
        bit got;
        got = 0;
        n = 0;
        while (!got && n <= max) begin
            rd(2'd0, v);
            if (v[3:2] == tgt) got = 1;
            else begin
                step();
                n++;
            end
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $error("FAIL wait_state_%0d observed=timeout required=state within %0d edges", tgt, max);
        end
    endtask

    initial begin
        logic [31:0] v;
        int n;
        int unsigned e_green, r0, p, t1, k, g_exit;

        // Reset defaults
        step(); step(); step();
        reset = 1'b0;
        push("rst_ctrl", 32'd0);
        push("rst_green", 32'd4000);
        push("rst_yellow", 32'd1000);
        push("rst_red", 32'd5000);
        push("rst_lamp", 32'd1);
        rd(2'd0, v); check(v);
        rd(2'd1, v); check(v);
        rd(2'd2, v); check(v);
        rd(2'd3, v); check(v);
        check({29'd0, out_port});

        // Basic sequence R=2 G=3 Y=1
        wr(2'd3, 32'd2);
        wr(2'd1, 32'hFFFF_0003);
        wr(2'd2, 32'd1);
        push("dur_green_masked", 32'd3);
        rd(2'd1, v); check(v);
        wr(2'd0, 32'd1);
        push("ctrl_run_still_stop", 32'd1);
        push("run_to_red", 32'd1);
        push("red_len", 32'd8);
        push("green_lamp", 32'd4);
        push("green_len", 32'd12);
        push("yellow_lamp", 32'd2);
        push("yellow_len", 32'd4);
        push("red2_lamp", 32'd1);
        rd(2'd0, v); check(v);
        wait_state(2'd1, 10, n);  check(n);
        wait_state(2'd2, 100, n); check(n);
        check({29'd0, out_port});
        wait_state(2'd3, 100, n); check(n);
        check({29'd0, out_port});
        wait_state(2'd1, 100, n); check(n);
        check({29'd0, out_port});

        // Run cleared on the same edge as YELLOW expiry (Y=2)
        wr(2'd2, 32'd2);
        wait_state(2'd3, 200, n);
        for (int i = 0; i < 7; i++) step();
        wr(2'd0, 32'd0);
        push("stop_ctrl", 32'd0);
        push("stop_lamp", 32'd1);
        push("stop_hold_ctrl", 32'd0);
        push("stop_hold_lamp", 32'd1);
        rd(2'd0, v); check(v);
        check({29'd0, out_port});
        for (int i = 0; i < 10; i++) step();
        rd(2'd0, v); check(v);
        check({29'd0, out_port});

        // Zero durations, GREEN rewritten mid-phase
        wr(2'd1, 32'd0);
        wr(2'd2, 32'd0);
        wr(2'd3, 32'd0);
        wr(2'd0, 32'd1);
        push("z_run_to_red", 32'd1);
        push("z_red_len", 32'd4);
        push("z_green_rest", 32'd3);
        push("z_yellow_len", 32'd4);
        push("z_red2_len", 32'd4);
        push("z_green_new_len", 32'd20);
        wait_state(2'd1, 10, n);  check(n);
        wait_state(2'd2, 100, n); check(n);
        wr(2'd1, 32'd5);
        wait_state(2'd3, 100, n); check(n);
        wait_state(2'd1, 100, n); check(n);
        wait_state(2'd2, 100, n); check(n);
        wait_state(2'd3, 100, n); check(n);

        // Pedestrian request shortens GREEN
        wr(2'd0, 32'd0);
        wr(2'd1, 32'd1000);
        wr(2'd2, 32'd1);
        wr(2'd3, 32'd1);
        push("ped_idle_ctrl", 32'd0);
        rd(2'd0, v); check(v);
        wr(2'd0, 32'd1);
        wait_state(2'd1, 10, n);
        wait_state(2'd2, 100, n);
        e_green = cyc;
        for (int i = 0; i < 41; i++) step();
        r0 = cyc;
        ped_req = 1'b1;
        step(); step();
        ped_req = 1'b0;
        push("ped_not_yet", 32'd0);
        push("ped_set", 32'd1);
        rd(2'd0, v); check({31'd0, v[4]});
        step();
        p = cyc;
        rd(2'd0, v); check({31'd0, v[4]});
        k = ((p + 1 - e_green) / TD) + 1;
        t1 = e_green + k * TD;
        g_exit = t1 + 499 * TD;
        push("ped_latency", 32'd3);
        push("ped_green_rest", g_exit - p);
        push("ped_kept_in_yellow", 32'd1);
        push("ped_yellow_len", 32'd4);
        push("ped_cleared_on_red", 32'd0);
        check(p - r0);
        wait_state(2'd3, 3000, n); check(n);
        rd(2'd0, v); check({31'd0, v[4]});
        wait_state(2'd1, 100, n); check(n);
        rd(2'd0, v); check({31'd0, v[4]});

        // Reset mid-GREEN with run and ped pending set
        wait_state(2'd2, 100, n);
        wr(2'd0, 32'd3);
        step(); step();
        reset = 1'b1;
        step();
        push("mid_rst_ctrl", 32'd0);
        push("mid_rst_lamp", 32'd1);
        push("mid_rst_green", 32'd4000);
        push("mid_rst_yellow", 32'd1000);
        push("mid_rst_red", 32'd5000);
        rd(2'd0, v); check(v);
        check({29'd0, out_port});
        rd(2'd1, v); check(v);
        rd(2'd2, v); check(v);
        rd(2'd3, v); check(v);
        reset = 1'b0;
        step(); step();

        if (sb_q.size() != 0) begin
            n_vec++;
            n_err++;
            $error("FAIL scoreboard_leftover observed=%0d required=0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
